text_pixel_renderer: RTL and testbench

TEXT_PIXEL_RENDERER -- requirements
Module: text_pixel_renderer

---
 rtl/text_pixel_renderer_pkg.sv | 26 ++
 rtl/text_pixel_renderer_blink_divider.sv | 47 ++++
 rtl/text_pixel_renderer.sv | 143 ++++++++++++++
 tb/tb_text_pixel_renderer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pixel_renderer_pkg.sv
// Shared constants, state encoding and parameter range checks for the text
// pixel renderer and its blink divider.
package text_pixel_renderer_pkg;

  localparam int CHAR_W_DEFAULT    = 8;
  localparam int CHAR_W_MIN        = 4;
  localparam int CHAR_W_MAX        = 16;
  localparam int COLOR_W_DEFAULT   = 3;
  localparam int COLOR_W_MIN       = 1;
  localparam int COLOR_W_MAX       = 8;
  localparam int BLINK_DIV_DEFAULT = 36;
  localparam int BLINK_DIV_MIN     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_HOLD = 2'd2
  } render_state_e;

  function automatic bit params_ok(input int char_w, input int color_w, input int blink_div);
    return (char_w >= CHAR_W_MIN) && (char_w <= CHAR_W_MAX) &&
           (color_w >= COLOR_W_MIN) && (color_w <= COLOR_W_MAX) &&
           (blink_div >= BLINK_DIV_MIN);
  endfunction

endpackage

// File: rtl/text_pixel_renderer_blink_divider.sv
// Frame-rate divider: blink_phase toggles every BLINK_DIV frames and
// cursor_phase toggles at half that rate.
module blink_divider
  import text_pixel_renderer_pkg::*;
#(
  parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  output logic blink_phase,
  output logic cursor_phase
);

  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] frame_cnt_reg;
  logic             blink_reg;
  logic             cursor_reg;
  // Remembers whether the next blink toggle is the second of a pair.
  logic             pair_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_reg <= '0;
      blink_reg     <= 1'b0;
      cursor_reg    <= 1'b0;
      pair_reg      <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt_reg == CNT_LAST) begin
        frame_cnt_reg <= '0;
        blink_reg     <= ~blink_reg;
        pair_reg      <= ~pair_reg;
        if (pair_reg) begin
          cursor_reg <= ~cursor_reg;
        end
      end else begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
    end
  end

  assign blink_phase  = blink_reg;
  assign cursor_phase = cursor_reg;

endmodule

// File: rtl/text_pixel_renderer.sv
// Serialises one glyph row per character cell into DAC colours, applying
// attribute blink and cursor inversion, with optional double-width pixels.
module text_pixel_renderer
  import text_pixel_renderer_pkg::*;
#(
  parameter int CHAR_W    = CHAR_W_DEFAULT,
  parameter int COLOR_W   = COLOR_W_DEFAULT,
  parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               drawing,
  input  logic               char_start,
  input  logic [CHAR_W-1:0]  row_pixels,
  input  logic [COLOR_W-1:0] foreground,
  input  logic [COLOR_W-1:0] background,
  input  logic               blink,
  input  logic               cursor_here,
  input  logic               cursor_row,
  input  logic               xdouble,
  input  logic               frame_start,
  output logic [COLOR_W-1:0] dac,
  output logic               blink_phase
);

  localparam int IDX_W = $clog2(CHAR_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(CHAR_W - 1);

  if (!params_ok(CHAR_W, COLOR_W, BLINK_DIV)) begin : g_param_error
    $error("text_pixel_renderer: parameter out of range");
  end

  render_state_e      state_reg, state_next;
  logic [CHAR_W-1:0]  pix_reg, pix_next;
  logic [COLOR_W-1:0] fg_reg, fg_next;
  logic [COLOR_W-1:0] bg_reg, bg_next;
  logic               blink_reg, blink_next;
  logic               cursor_reg, cursor_next;
  logic               xdouble_reg, xdouble_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  // In double-width mode, set while the second clock of a pixel is shown.
  logic               half_reg, half_next;
  logic [COLOR_W-1:0] dac_reg, dac_next;

  logic cursor_phase;
  logic bit_on;
  logic pixel_on;

  blink_divider #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink_divider (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .blink_phase  (blink_phase),
    .cursor_phase (cursor_phase)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      pix_reg     <= '0;
      fg_reg      <= '0;
      bg_reg      <= '0;
      blink_reg   <= 1'b0;
      cursor_reg  <= 1'b0;
      xdouble_reg <= 1'b0;
      idx_reg     <= '0;
      half_reg    <= 1'b0;
      dac_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pix_reg     <= pix_next;
      fg_reg      <= fg_next;
      bg_reg      <= bg_next;
      blink_reg   <= blink_next;
      cursor_reg  <= cursor_next;
      xdouble_reg <= xdouble_next;
      idx_reg     <= idx_next;
      half_reg    <= half_next;
      dac_reg     <= dac_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pix_next     = pix_reg;
    fg_next      = fg_reg;
    bg_next      = bg_reg;
    blink_next   = blink_reg;
    cursor_next  = cursor_reg;
    xdouble_next = xdouble_reg;
    idx_next     = idx_reg;
    half_next    = half_reg;

    if (char_start) begin
      pix_next     = row_pixels;
      fg_next      = foreground;
      bg_next      = background;
      blink_next   = blink;
      cursor_next  = cursor_here & cursor_row;
      xdouble_next = xdouble;
      idx_next     = IDX_TOP;
      half_next    = 1'b0;
      state_next   = ST_SHOW;
    end else begin
      case (state_reg)
        ST_SHOW: begin
          if (!xdouble_reg || half_reg) begin
            half_next = 1'b0;
            if (idx_reg == '0) begin
              state_next = ST_HOLD;
            end else begin
              idx_next = idx_reg - 1'b1;
            end
          end else begin
            half_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The pixel driven this edge comes from the shadow set as it stood before the edge.
  always_comb begin
    bit_on   = (state_reg == ST_SHOW) ? pix_reg[idx_reg] : 1'b0;
    pixel_on = 1'b0;
    if (state_reg != ST_IDLE) begin
      pixel_on = (bit_on & (~blink_reg | blink_phase)) ^ (cursor_reg & cursor_phase);
    end
    if (!drawing) begin
      dac_next = '0;
    end else if (pixel_on) begin
      dac_next = fg_reg;
    end else begin
      dac_next = bg_reg;
    end
  end

  assign dac = dac_reg;

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Scoreboard bench for text_pixel_renderer: expected DAC values are queued as
// each cell is started and popped one per clock edge.
module tb_text_pixel_renderer;

  localparam int CW  = 8;
  localparam int COLW = 3;
  localparam int BD  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            drawing = 1'b0;
  logic            char_start = 1'b0;
  logic [CW-1:0]   row_pixels = '0;
  logic [COLW-1:0] foreground = '0;
  logic [COLW-1:0] background = '0;
  logic            blink = 1'b0;
  logic            cursor_here = 1'b0;
  logic            cursor_row = 1'b0;
  logic            xdouble = 1'b0;
  logic            frame_start = 1'b0;
  logic [COLW-1:0] dac;
  logic            blink_phase;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [COLW-1:0] exp_q[$];

  text_pixel_renderer #(
    .CHAR_W    (CW),
    .COLOR_W   (COLW),
    .BLINK_DIV (BD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .drawing     (drawing),
    .char_start  (char_start),
    .row_pixels  (row_pixels),
    .foreground  (foreground),
    .background  (background),
    .blink       (blink),
    .cursor_here (cursor_here),
    .cursor_row  (cursor_row),
    .xdouble     (xdouble),
    .frame_start (frame_start),
    .dac         (dac),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_bp();
    return logic'((frames / BD) % 2);
  endfunction

  function automatic logic model_cp();
    return logic'((frames / (2 * BD)) % 2);
  endfunction

  // Expected colour from the bench's own view of blink/cursor phase.
  function automatic logic [COLW-1:0] model_color(input logic b, input logic bl, input logic cf,
                                                  input logic drw, input logic [COLW-1:0] fg,
                                                  input logic [COLW-1:0] bg);
    logic on;
    on = (b & (~bl | model_bp())) ^ (cf & model_cp());
    if (!drw) return '0;
    return on ? fg : bg;
  endfunction

  // Queues CW pixels plus one HOLD pixel for the cell currently on the inputs.
  task automatic push_cell();
    for (int k = 1; k <= CW; k++) begin
      exp_q.push_back(model_color(row_pixels[CW-k], blink, cursor_here & cursor_row,
                                  drawing, foreground, background));
    end
    exp_q.push_back(model_color(1'b0, blink, cursor_here & cursor_row,
                                drawing, foreground, background));
  endtask

  task automatic test_reset();
    logic [COLW-1:0] got;
    reset = 1'b1; drawing = 1'b1; char_start = 1'b1; frame_start = 1'b1;
    row_pixels = 8'hFF; foreground = 3'd7; background = 3'd5;
    tick();
    checks++;
    if (dac !== 3'd0 || blink_phase !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dac=%0d blink_phase=%0b expected dac=0 blink_phase=0", dac, blink_phase);
    end else $display("pass reset_state: dac=%0d blink_phase=%0b", dac, blink_phase);
    reset = 1'b0; char_start = 1'b0; frame_start = 1'b0;
    frames = 0;
    tick();
    got = dac;
    checks++;
    if (got !== 3'd0) begin
      errors++;
      $display("FAIL idle_dac: dac=%0d expected 0", got);
    end else $display("pass idle_dac: dac=%0d", got);
  endtask

  task automatic test_basic();
    logic [COLW-1:0] tbl [10];
    logic [COLW-1:0] e;
    int n;
    tbl = '{3'd7, 3'd1, 3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    drawing = 1'b1; xdouble = 1'b0; blink = 1'b0; cursor_here = 1'b0; cursor_row = 1'b0;
    row_pixels = 8'b1010_0000; foreground = 3'd7; background = 3'd1; char_start = 1'b1;
    tick();
    char_start = 1'b0;
    for (int i = 0; i < 10; i++) exp_q.push_back(tbl[i]);
    n = 0;
    while (exp_q.size() > 0) begin
      tick();
      n++;
      e = exp_q.pop_front();
      checks++;
      if (dac !== e) begin
        errors++;
        $display("FAIL basic E+%0d: dac=%0d expected %0d", n, dac, e);
      end else $display("pass basic E+%0d: dac=%0d", n, dac);
    end
  endtask

  task automatic test_xdouble();
    logic [COLW-1:0] tbl [8];
    logic [COLW-1:0] e;
    int n;
    tbl = '{3'd7, 3'd7, 3'd1, 3'd1, 3'd7, 3'd7, 3'd1, 3'd1};
    drawing = 1'b1; xdouble = 1'b1;
    row_pixels = 8'b1010_0000; foreground = 3'd7; background = 3'd1; char_start = 1'b1;
    tick();
    char_start = 1'b0; xdouble = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(tbl[i]);
    for (int i = 0; i < 9; i++) exp_q.push_back(3'd1);
    n = 0;
    while (exp_q.size() > 0) begin
      tick();
      n++;
      e = exp_q.pop_front();
      checks++;
      if (dac !== e) begin
        errors++;
        $display("FAIL xdouble E+%0d: dac=%0d expected %0d", n, dac, e);
      end else $display("pass xdouble E+%0d: dac=%0d", n, dac);
    end
  endtask

  task automatic test_back_to_back();
    logic [COLW-1:0] e;
    int n;
    drawing = 1'b1; xdouble = 1'b0;
    row_pixels = 8'b1010_0000; foreground = 3'd7; background = 3'd1; char_start = 1'b1;
    tick();
    char_start = 1'b0;
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd1);
    n = 0;
    while (exp_q.size() > 0) begin
      tick();
      n++;
      e = exp_q.pop_front();
      checks++;
      if (dac !== e) begin
        errors++;
        $display("FAIL reload_first E+%0d: dac=%0d expected %0d", n, dac, e);
      end else $display("pass reload_first E+%0d: dac=%0d", n, dac);
    end
    row_pixels = 8'hFF; foreground = 3'd2; background = 3'd1; char_start = 1'b1;
    tick();
    n++;
    char_start = 1'b0;
    checks++;
    if (dac !== 3'd7) begin
      errors++;
      $display("FAIL reload_edge E+%0d: dac=%0d expected 7", n, dac);
    end else $display("pass reload_edge E+%0d: dac=%0d", n, dac);
    for (int i = 0; i < 8; i++) exp_q.push_back(3'd2);
    exp_q.push_back(3'd1);
    while (exp_q.size() > 0) begin
      tick();
      n++;
      e = exp_q.pop_front();
      checks++;
      if (dac !== e) begin
        errors++;
        $display("FAIL reload_second E+%0d: dac=%0d expected %0d", n, dac, e);
      end else $display("pass reload_second E+%0d: dac=%0d", n, dac);
    end
  endtask

  // A frame_start rides along with each char_start after the first cell.
  task automatic test_blink();
    logic [COLW-1:0] e;
    drawing = 1'b1; xdouble = 1'b0; blink = 1'b1;
    row_pixels = 8'hFF; foreground = 3'd7; background = 3'd1;
    for (int f = 0; f < 6; f++) begin
      char_start = 1'b1;
      frame_start = (f > 0);
      tick();
      if (f > 0) frames++;
      char_start = 1'b0; frame_start = 1'b0;
      checks++;
      if (blink_phase !== model_bp()) begin
        errors++;
        $display("FAIL blink_phase frame %0d: blink_phase=%0b expected %0b", f, blink_phase, model_bp());
      end else $display("pass blink_phase frame %0d: blink_phase=%0b", f, blink_phase);
      push_cell();
      while (exp_q.size() > 0) begin
        tick();
        e = exp_q.pop_front();
        checks++;
        if (dac !== e) begin
          errors++;
          $display("FAIL blink_pixel frame %0d: dac=%0d expected %0d", f, dac, e);
        end else $display("pass blink_pixel frame %0d: dac=%0d", f, dac);
      end
    end
    blink = 1'b0;
  endtask

  task automatic test_cursor();
    logic [CW-1:0]   rows [4];
    logic            heres [4];
    logic            draws [4];
    logic [COLW-1:0] e;
    rows  = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    heres = '{1'b1, 1'b1, 1'b0, 1'b1};
    draws = '{1'b1, 1'b1, 1'b1, 1'b0};
    foreground = 3'd5; background = 3'd2; blink = 1'b0; xdouble = 1'b0;
    for (int c = 0; c < 4; c++) begin
      row_pixels = rows[c]; cursor_here = heres[c]; cursor_row = 1'b1;
      drawing = draws[c]; char_start = 1'b1;
      tick();
      char_start = 1'b0;
      push_cell();
      while (exp_q.size() > 0) begin
        tick();
        e = exp_q.pop_front();
        checks++;
        if (dac !== e) begin
          errors++;
          $display("FAIL cursor case %0d: dac=%0d expected %0d", c, dac, e);
        end else $display("pass cursor case %0d: dac=%0d", c, dac);
      end
    end
    drawing = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [COLW-1:0] tbl [4];
    tbl = '{3'd7, 3'd1, 3'd7, 3'd1};
    cursor_here = 1'b0; cursor_row = 1'b0; drawing = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    frames++;
    checks++;
    if (blink_phase !== model_bp()) begin
      errors++;
      $display("FAIL pre_reset_phase: blink_phase=%0b expected %0b", blink_phase, model_bp());
    end else $display("pass pre_reset_phase: blink_phase=%0b", blink_phase);
    row_pixels = 8'b1010_0000; foreground = 3'd7; background = 3'd1; char_start = 1'b1;
    tick();
    char_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (dac !== tbl[k-1]) begin
        errors++;
        $display("FAIL reset_mid E+%0d: dac=%0d expected %0d", k, dac, tbl[k-1]);
      end else $display("pass reset_mid E+%0d: dac=%0d", k, dac);
    end
    reset = 1'b1; char_start = 1'b1; frame_start = 1'b1;
    tick();
    reset = 1'b0; char_start = 1'b0; frame_start = 1'b0;
    frames = 0;
    checks++;
    if (dac !== 3'd0 || blink_phase !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid E+5: dac=%0d blink_phase=%0b expected 0 0", dac, blink_phase);
    end else $display("pass reset_mid E+5: dac=%0d blink_phase=%0b", dac, blink_phase);
    tick();
    checks++;
    if (dac !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid idle: dac=%0d expected 0", dac);
    end else $display("pass reset_mid idle: dac=%0d", dac);
    // Cursor phase must also be back at 0: a cursor cell with an empty row shows background.
    row_pixels = 8'h00; cursor_here = 1'b1; cursor_row = 1'b1; char_start = 1'b1;
    tick();
    char_start = 1'b0;
    tick();
    checks++;
    if (dac !== 3'd1) begin
      errors++;
      $display("FAIL reset_cursor_phase: dac=%0d expected 1", dac);
    end else $display("pass reset_cursor_phase: dac=%0d", dac);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_xdouble();
    test_back_to_back();
    test_blink();
    test_cursor();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
